// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: fixed-latency mult/div with HI/LO registers, stall
// request toward the hazard unit, and the mfhi/mflo read path for the E stage.
`timescale 1ns/1ps

module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_req_valid,
    input  logic [3:0]  E_op,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    input  logic        D_mdu_use,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] E_MDUAns,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state | meaning
    // IDLE  | no operation in flight; accepts mult/div and mthi/mtlo
    // RUN   | mult/div counting down; result held in p_hi/p_lo until commit
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [4:0] LP_MULT_CNT = MULT_CYCLES[4:0];
    localparam logic [4:0] LP_DIV_CNT  = DIV_CYCLES[4:0];
    localparam logic [1:0] LP_K_MULT   = 2'd0;
    localparam logic [1:0] LP_K_MULTU  = 2'd1;
    localparam logic [1:0] LP_K_DIV    = 2'd2;
    localparam logic [1:0] LP_K_DIVU   = 2'd3;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic [1:0]  r_pend_op;
    logic [1:0]  w_kind;
    logic        r_rt_zero;
    logic [31:0] r_p_hi;
    logic [31:0] r_p_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_idle;
    logic        w_is_md;
    logic        w_commit;
    logic        w_wr_hi;
    logic        w_wr_lo;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_uq_s;
    logic [31:0] w_ur_s;
    logic [31:0] w_uq_u;
    logic [31:0] w_ur_u;

    assign w_idle  = (r_state == S_IDLE);
    assign w_is_md = (E_op >= 4'd1) && (E_op <= 4'd4);
    assign start   = E_req_valid && w_is_md && w_idle;
    assign busy    = (r_state == S_RUN);
    assign stall   = D_mdu_use && (start || busy);
    assign w_wr_hi = E_req_valid && w_idle && (E_op == 4'd5);
    assign w_wr_lo = E_req_valid && w_idle && (E_op == 4'd6);
    assign hi      = r_hi;
    assign lo      = r_lo;

    // Signed divide runs on magnitudes; a zero divisor is swapped for 1 so the
    // datapath stays defined, and the commit is suppressed later instead.
    assign w_smul   = $signed({{32{E_rs_data[31]}}, E_rs_data}) *
                      $signed({{32{E_rt_data[31]}}, E_rt_data});
    assign w_umul   = {32'd0, E_rs_data} * {32'd0, E_rt_data};
    assign w_a_mag  = E_rs_data[31] ? (~E_rs_data + 32'd1) : E_rs_data;
    assign w_b_mag  = E_rt_data[31] ? (~E_rt_data + 32'd1) : E_rt_data;
    assign w_b_safe = (E_rt_data == 32'd0) ? 32'd1 : E_rt_data;
    assign w_uq_s   = w_a_mag / ((w_b_mag == 32'd0) ? 32'd1 : w_b_mag);
    assign w_ur_s   = w_a_mag % ((w_b_mag == 32'd0) ? 32'd1 : w_b_mag);
    assign w_uq_u   = E_rs_data / w_b_safe;
    assign w_ur_u   = E_rs_data % w_b_safe;

    always_comb begin
        w_kind   = LP_K_MULT;
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (E_op)
            4'd1: begin
                w_kind   = LP_K_MULT;
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
            end
            4'd2: begin
                w_kind   = LP_K_MULTU;
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
            end
            4'd3: begin
                w_kind   = LP_K_DIV;
                w_res_lo = (E_rs_data[31] ^ E_rt_data[31]) ? (~w_uq_s + 32'd1) : w_uq_s;
                w_res_hi = E_rs_data[31] ? (~w_ur_s + 32'd1) : w_ur_s;
            end
            4'd4: begin
                w_kind   = LP_K_DIVU;
                w_res_lo = w_uq_u;
                w_res_hi = w_ur_u;
            end
            default: ;
        endcase
    end

    always_comb begin
        E_MDUAns = 32'd0;
        if (E_req_valid && (E_op == 4'd7)) begin
            E_MDUAns = r_hi;
        end else if (E_req_valid && (E_op == 4'd8)) begin
            E_MDUAns = r_lo;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = ((E_op == 4'd1) || (E_op == 4'd2)) ? LP_MULT_CNT : LP_DIV_CNT;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = !(((r_pend_op == LP_K_DIV) || (r_pend_op == LP_K_DIVU)) && r_rt_zero);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_pend_op <= 2'd0;
            r_rt_zero <= 1'b0;
            r_p_hi    <= 32'd0;
            r_p_lo    <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (start) begin
                r_pend_op <= w_kind;
                r_rt_zero <= (E_rt_data == 32'd0);
                r_p_hi    <= w_res_hi;
                r_p_lo    <= w_res_lo;
            end
            if (w_commit) begin
                r_hi <= r_p_hi;
                r_lo <= r_p_lo;
            end else begin
                if (w_wr_hi) r_hi <= E_rs_data;
                if (w_wr_lo) r_lo <= E_rs_data;
            end
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed self-checking bench for mdu_sched with default latencies (mult 5, div 10).
`timescale 1ns/1ps

module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_req_valid;
    logic [3:0]  E_op;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        D_mdu_use;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] E_MDUAns;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mdu_sched dut (
        .clk        (clk),
        .reset      (reset),
        .E_req_valid(E_req_valid),
        .E_op       (E_op),
        .E_rs_data  (E_rs_data),
        .E_rt_data  (E_rt_data),
        .D_mdu_use  (D_mdu_use),
        .start      (start),
        .busy       (busy),
        .stall      (stall),
        .E_MDUAns   (E_MDUAns),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        E_req_valid = 1'b0;
        E_op        = 4'd0;
        E_rs_data   = 32'd0;
        E_rt_data   = 32'd0;
        D_mdu_use   = 1'b0;
    endtask

    // Issue one mult/div, count busy and stall cycles; returns in the first
    // cycle after busy falls, 1 ns after the falling clock edge.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp, input logic duse);
        int n;
        int nst;
        n   = 0;
        nst = 0;
        @(negedge clk);
        E_req_valid = 1'b1;
        E_op        = op;
        E_rs_data   = a;
        E_rt_data   = b;
        D_mdu_use   = duse;
        #1;
        chk({tag, "_start"}, {31'd0, start}, 32'd1);
        chk({tag, "_stall_start"}, {31'd0, stall}, {31'd0, duse});
        @(negedge clk);
        E_req_valid = 1'b0;
        E_op        = 4'd0;
        #1;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (stall === 1'b1) nst++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_busy_len"}, n, n_exp);
        chk({tag, "_stall_len"}, nst, duse ? n_exp : 0);
        chk({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
        D_mdu_use = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ans", E_MDUAns, 32'd0);
        reset = 1'b1;

        run_md("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        run_md("divu", 4'd4, 32'd7, 32'd2, 10, 1'b0);
        chk("divu_hi", hi, 32'd1);
        chk("divu_lo", lo, 32'd3);

        run_md("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1);
        E_req_valid = 1'b1;
        E_op        = 4'd8;
        #1;
        chk("multu_mflo", E_MDUAns, 32'h0000_0001);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        E_op = 4'd7;
        #1;
        chk("multu_mfhi", E_MDUAns, 32'hFFFF_FFFE);

        @(negedge clk);
        idle_in();
        E_req_valid = 1'b1;
        E_op        = 4'd5;
        E_rs_data   = 32'h1234_5678;
        D_mdu_use   = 1'b1;
        #1;
        chk("mthi_start", {31'd0, start}, 32'd0);
        chk("mthi_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        E_op      = 4'd7;
        E_rs_data = 32'd0;
        D_mdu_use = 1'b0;
        #1;
        chk("mfhi_ans", E_MDUAns, 32'h1234_5678);
        chk("mfhi_stall", {31'd0, stall}, 32'd0);
        E_req_valid = 1'b0;
        #1;
        chk("mfhi_novalid", E_MDUAns, 32'd0);

        run_md("div0", 4'd3, 32'd55, 32'd0, 10, 1'b0);
        chk("div0_hi", hi, 32'h1234_5678);
        chk("div0_lo", lo, 32'h0000_0001);

        run_md("ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_lo", lo, 32'h8000_0000);

        // ops presented while RUN must be ignored
        @(negedge clk);
        idle_in();
        E_req_valid = 1'b1;
        E_op        = 4'd1;
        E_rs_data   = 32'd2;
        E_rt_data   = 32'd3;
        @(negedge clk);
        idle_in();
        @(negedge clk);
        E_req_valid = 1'b1;
        E_op        = 4'd5;
        E_rs_data   = 32'hDEAD_BEEF;
        #1;
        chk("run_mthi_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        E_op      = 4'd1;
        E_rs_data = 32'd7;
        E_rt_data = 32'd7;
        #1;
        chk("run_mult_start", {31'd0, start}, 32'd0);
        idle_in();
        repeat (6) @(negedge clk);
        #1;
        chk("run_busy", {31'd0, busy}, 32'd0);
        chk("run_hi", hi, 32'd0);
        chk("run_lo", lo, 32'd6);

        @(negedge clk);
        E_req_valid = 1'b0;
        E_op        = 4'd1;
        E_rs_data   = 32'd5;
        E_rt_data   = 32'd5;
        #1;
        chk("inv_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        idle_in();
        #1;
        chk("inv_busy", {31'd0, busy}, 32'd0);
        chk("inv_hi", hi, 32'd0);
        chk("inv_lo", lo, 32'd6);
        E_req_valid = 1'b1;
        E_op        = 4'd9;
        #1;
        chk("op9_ans", E_MDUAns, 32'd0);
        chk("op9_start", {31'd0, start}, 32'd0);

        // reset during busy cycle 4 of a divide
        @(negedge clk);
        E_req_valid = 1'b1;
        E_op        = 4'd3;
        E_rs_data   = 32'd100;
        E_rt_data   = 32'd3;
        @(negedge clk);
        idle_in();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (15) @(negedge clk);
        #1;
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);
        chk("abort_late_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
